mips_bus_arbiter: RTL and testbench
===================================

// Module: mips_bus_arbiter
// PURPOSE
//  Shares one Avalon-style memory bus (address/read/write/writedata/byteenable/waitrequest/readdata)
//  between two requesters of the MIPS core: M0 = instruction fetch, M1 = load/store data port.
//  Round-robin, transaction-granular grant; routes fixed-latency read data back to the issuing master.
//  Sits between the core's fetch/data ports and the single bus seen by the testbench RAM.
// PARAMETERS
//  READ_LATENCY   1   cycles from read acceptance (read=1 & waitrequest=0 at a posedge) to readdata valid; range 1..4
//  TIMEOUT_CYCLES 0   max consecutive stalled cycles of a granted access before bus_error; 0 = check disabled
// PORTS
//  clk            in   1   bus clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  mN_address     in   32  byte address from master N (N = 0, 1)
//  mN_read        in   1   read request; held until mN_waitrequest=0
//  mN_write       in   1   write request; held until mN_waitrequest=0; never asserted together with mN_read
//  mN_writedata   in   32  write data
//  mN_byteenable  in   4   byte lanes; bit3 = [31:24]
//  mN_waitrequest out  1   1 = not accepted this cycle
//  mN_readdata    out  32  read data; meaningful only while mN_rdvalid=1
//  mN_rdvalid     out  1   one-cycle pulse, READ_LATENCY cycles after mN read accepted
//  s_address      out  32  slave bus address
//  s_read         out  1   slave read strobe
//  s_write        out  1   slave write strobe
//  s_writedata    out  32  slave write data
//  s_byteenable   out  4   slave byte lanes
//  s_waitrequest  in   1   slave stall
//  s_readdata     in   32  slave read data, valid READ_LATENCY cycles after acceptance
//  bus_error      out  1   sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  Reset values: state=IDLE, last_grant=M1 (so M0 wins first tie), s_read=s_write=0, s_* data buses=0,
//   mN_waitrequest=1, mN_rdvalid=0, bus_error=0, read tracker empty, timeout counter=0.
//  FSM states: IDLE, GNT0, GNT1. Grant is registered: a request seen in IDLE costs one arbitration cycle.
//   IDLE: if only one master requests -> GNTn; if both -> the one that is not last_grant; else stay.
//   GNTn: s_* driven combinationally from master n; s_read/s_write = mn_read/mn_write;
//    mn_waitrequest = s_waitrequest; other master's waitrequest = 1.
//   Acceptance = (mn_read|mn_write) & ~s_waitrequest at posedge: last_grant<=n; next state chosen by the
//    IDLE rule on the other master's request plus mn's (back-to-back, no idle cycle); none -> IDLE.
//   Granted master drops its request before acceptance (protocol error): return to IDLE, nothing recorded.
//  In IDLE: s_read=s_write=0, s_address/s_writedata/s_byteenable=0, both mN_waitrequest=1.
//  Read return: accepted read pushes {valid=1, owner=n} into a READ_LATENCY-deep shift register; the tail
//   entry drives mowner_rdvalid=1 and mowner_readdata=s_readdata that cycle; mN_readdata=0 when not valid.
//   Writes push {valid=0}. Up to READ_LATENCY reads in flight; owners interleave freely.
//  Timeout: counter increments each GNTx cycle with s_waitrequest=1 and an active strobe, clears on
//   acceptance or leaving GNTx; reaching TIMEOUT_CYCLES sets bus_error; FSM keeps waiting (no abort).
//  Reset mid-transaction: strobes drop the same cycle reset is sampled; in-flight reads discarded,
//   no rdvalid pulses after reset.
// STRUCTURE
//  mips_bus_pkg: arb_state_t {IDLE,GNT0,GNT1}, owner_t (1 bit), BUS_AW=32, BUS_DW=32, BUS_BEW=4.
//  Sub-module mips_bus_read_tracker: parameterised shift register of {valid,owner}; push/tail outputs.
//  Top holds FSM, round-robin pointer, muxes, timeout counter.
// TESTING
//  1 M0 read 0xBFC00000 alone, s_waitrequest=0 -> s_read 1 cycle after request, m0_rdvalid 1 cycle later.
//  2 M0,M1 request same cycle after reset -> M0 granted first, M1 back-to-back next cycle, no IDLE gap.
//  3 Both request continuously for 8 accesses -> grants alternate M0,M1,M0,..., each 4 accepts.
//  4 M1 write 0x1122 be=4'b0011 with s_waitrequest=1 for 3 cycles -> m1_waitrequest=1 for 3, m0 blocked, 1 s_write accept.
//  5 READ_LATENCY=2, M0 read then M1 read back-to-back -> rdvalid pulses m0 then m1 with correct data.
//  6 TIMEOUT_CYCLES=4, s_waitrequest stuck 1 -> bus_error rises on 4th stall, held; reset clears it and all outputs.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types, bus widths and the round-robin pick rule for the MIPS bus arbiter
package mips_bus_pkg;
    localparam int BUS_AW  = 32;
    localparam int BUS_DW  = 32;
    localparam int BUS_BEW = 4;
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;
    typedef logic owner_t;
    localparam owner_t M0 = 1'b0;
    localparam owner_t M1 = 1'b1;
    // On a tie the master that was not granted last wins
    function automatic arb_state_t pick(input logic r0, input logic r1, input owner_t last);
        return (r0 && r1) ? ((last == M0) ? GNT1 : GNT0) : r0 ? GNT0 : r1 ? GNT1 : IDLE;
    endfunction
endpackage

// File: rtl/mips_bus_read_tracker.sv
// mips_bus_read_tracker: fixed-latency shift register remembering which master owns each in-flight read
module mips_bus_read_tracker
    import mips_bus_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_valid,
    input  owner_t push_owner,
    output logic   tail_valid,
    output owner_t tail_owner
);
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] own;
    // Shift one entry per cycle; writes and idle cycles push an invalid slot
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            own   <= '0;
        end else begin
            valid[0] <= push_valid;
            own[0]   <= push_owner;
            for (int i = 1; i < DEPTH; i++) begin
                valid[i] <= valid[i-1];
                own[i]   <= own[i-1];
            end
        end
    end
    assign tail_valid = valid[DEPTH-1];
    assign tail_owner = own[DEPTH-1];
endmodule

// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter: round-robin, transaction-granular sharing of one Avalon-style bus between fetch and data ports
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BUS_AW-1:0]  m0_address,
    input  logic               m0_read,
    input  logic               m0_write,
    input  logic [BUS_DW-1:0]  m0_writedata,
    input  logic [BUS_BEW-1:0] m0_byteenable,
    output logic               m0_waitrequest,
    output logic [BUS_DW-1:0]  m0_readdata,
    output logic               m0_rdvalid,
    input  logic [BUS_AW-1:0]  m1_address,
    input  logic               m1_read,
    input  logic               m1_write,
    input  logic [BUS_DW-1:0]  m1_writedata,
    input  logic [BUS_BEW-1:0] m1_byteenable,
    output logic               m1_waitrequest,
    output logic [BUS_DW-1:0]  m1_readdata,
    output logic               m1_rdvalid,
    output logic [BUS_AW-1:0]  s_address,
    output logic               s_read,
    output logic               s_write,
    output logic [BUS_DW-1:0]  s_writedata,
    output logic [BUS_BEW-1:0] s_byteenable,
    input  logic               s_waitrequest,
    input  logic [BUS_DW-1:0]  s_readdata,
    output logic               bus_error
);
    localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);
    arb_state_t  state, state_nx;
    owner_t      last_grant, gnt, tail_owner;
    logic        sel0, sel1, req0, req1, req_g, accept, stall, tail_valid;
    logic [31:0] stall_cnt;

    assign req0   = m0_read | m0_write;
    assign req1   = m1_read | m1_write;
    assign sel0   = !reset && state == GNT0;
    assign sel1   = !reset && state == GNT1;
    assign gnt    = (state == GNT1) ? M1 : M0;
    assign req_g  = sel0 ? req0 : sel1 & req1;
    assign accept = req_g & ~s_waitrequest;
    assign stall  = req_g & s_waitrequest;

    // Route the granted master onto the slave bus; reset drops strobes in the same cycle
    always_comb begin
        s_address      = sel0 ? m0_address    : sel1 ? m1_address    : '0;
        s_read         = sel0 ? m0_read       : sel1 & m1_read;
        s_write        = sel0 ? m0_write      : sel1 & m1_write;
        s_writedata    = sel0 ? m0_writedata  : sel1 ? m1_writedata  : '0;
        s_byteenable   = sel0 ? m0_byteenable : sel1 ? m1_byteenable : '0;
        m0_waitrequest = sel0 ? s_waitrequest : 1'b1;
        m1_waitrequest = sel1 ? s_waitrequest : 1'b1;
    end

    // Next grant: arbitrate from IDLE, chain back-to-back on acceptance, abandon a dropped request
    always_comb begin
        state_nx = (state == IDLE) ? pick(req0, req1, last_grant)
                 : !req_g          ? IDLE
                 : accept          ? pick(req0, req1, gnt)
                 :                   state;
    end

    // Grant register, round-robin pointer and stall watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= M1;
            stall_cnt  <= '0;
            bus_error  <= 1'b0;
        end else begin
            state     <= state_nx;
            if (accept) last_grant <= gnt;
            stall_cnt <= stall ? ((stall_cnt < TO) ? stall_cnt + 32'd1 : stall_cnt) : '0;
            if (TIMEOUT_CYCLES != 0 && stall && stall_cnt + 32'd1 == TO) bus_error <= 1'b1;
        end
    end

    mips_bus_read_tracker #(.DEPTH(READ_LATENCY)) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .push_valid (accept & s_read),
        .push_owner (gnt),
        .tail_valid (tail_valid),
        .tail_owner (tail_owner)
    );

    assign m0_rdvalid  = !reset && tail_valid && tail_owner == M0;
    assign m1_rdvalid  = !reset && tail_valid && tail_owner == M1;
    assign m0_readdata = m0_rdvalid ? s_readdata : '0;
    assign m1_readdata = m1_rdvalid ? s_readdata : '0;
endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb_mips_bus_arbiter: directed checks of two arbiters (latency 1 / no timeout, latency 2 / timeout 4) on shared stimulus
module tb_mips_bus_arbiter;
    logic        clk = 0, reset = 1;
    logic [31:0] m0_address = 0, m0_writedata = 0, m1_address = 0, m1_writedata = 0, s_readdata = 0;
    logic [3:0]  m0_byteenable = 0, m1_byteenable = 0;
    logic        m0_read = 0, m0_write = 0, m1_read = 0, m1_write = 0, s_waitrequest = 0;
    logic        a_m0_waitrequest, a_m0_rdvalid, a_m1_waitrequest, a_m1_rdvalid, a_s_read, a_s_write, a_bus_error;
    logic [31:0] a_m0_readdata, a_m1_readdata, a_s_address, a_s_writedata;
    logic [3:0]  a_s_byteenable;
    logic        b_m0_waitrequest, b_m0_rdvalid, b_m1_waitrequest, b_m1_rdvalid, b_s_read, b_s_write, b_bus_error;
    logic [31:0] b_m0_readdata, b_m1_readdata, b_s_address, b_s_writedata;
    logic [3:0]  b_s_byteenable;
    int checks = 0, failures = 0;
    int n0, n1, acc;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.READ_LATENCY(1), .TIMEOUT_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable), .m0_waitrequest(a_m0_waitrequest), .m0_readdata(a_m0_readdata),
        .m0_rdvalid(a_m0_rdvalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable), .m1_waitrequest(a_m1_waitrequest), .m1_readdata(a_m1_readdata),
        .m1_rdvalid(a_m1_rdvalid),
        .s_address(a_s_address), .s_read(a_s_read), .s_write(a_s_write), .s_writedata(a_s_writedata),
        .s_byteenable(a_s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .bus_error(a_bus_error)
    );

    mips_bus_arbiter #(.READ_LATENCY(2), .TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_byteenable(m0_byteenable), .m0_waitrequest(b_m0_waitrequest), .m0_readdata(b_m0_readdata),
        .m0_rdvalid(b_m0_rdvalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_byteenable(m1_byteenable), .m1_waitrequest(b_m1_waitrequest), .m1_readdata(b_m1_readdata),
        .m1_rdvalid(b_m1_rdvalid),
        .s_address(b_s_address), .s_read(b_s_read), .s_write(b_s_write), .s_writedata(b_s_writedata),
        .s_byteenable(b_s_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .bus_error(b_bus_error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        reset = 1;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0; s_waitrequest = 0;
        nx();
        nx();
        reset = 0;
    endtask

    initial begin
        rst_pulse();
        #2;
        chk("rst_m0_wait", a_m0_waitrequest, 1);
        chk("rst_m1_wait", a_m1_waitrequest, 1);
        chk("rst_sread", a_s_read, 0);
        chk("rst_swrite", a_s_write, 0);
        chk("rst_saddr", a_s_address, 0);
        chk("rst_rdvalid", a_m0_rdvalid, 0);
        chk("rst_err_b", b_bus_error, 0);

        // single M0 read, one arbitration cycle then latency 1 return
        nx(); m0_address = 32'hBFC00000; m0_read = 1; #2;
        chk("t1_idle_sread", a_s_read, 0);
        chk("t1_idle_wait", a_m0_waitrequest, 1);
        nx(); #2;
        chk("t1_sread", a_s_read, 1);
        chk("t1_saddr", a_s_address, 32'hBFC00000);
        chk("t1_wait", a_m0_waitrequest, 0);
        nx(); m0_read = 0; s_readdata = 32'hDEADBEEF; #2;
        chk("t1_rdvalid", a_m0_rdvalid, 1);
        chk("t1_rdata", a_m0_readdata, 32'hDEADBEEF);
        chk("t1_m1_rdvalid", a_m1_rdvalid, 0);
        chk("t1_sread_drop", a_s_read, 0);
        chk("t1_b_early", b_m0_rdvalid, 0);
        nx(); #2;
        chk("t1_rdvalid_end", a_m0_rdvalid, 0);
        chk("t1_rdata_zero", a_m0_readdata, 0);
        chk("t1_b_lat2", b_m0_rdvalid, 1);

        // simultaneous requests after reset: M0 first, M1 back-to-back; latency 2 ordering on dut_b
        rst_pulse();
        nx(); m0_address = 32'h100; m0_read = 1; m1_address = 32'h200; m1_read = 1; #2;
        chk("t2_idle", a_s_read, 0);
        nx(); #2;
        chk("t2_g0_addr", a_s_address, 32'h100);
        chk("t2_g0_w0", a_m0_waitrequest, 0);
        chk("t2_g0_w1", a_m1_waitrequest, 1);
        nx(); m0_read = 0; s_readdata = 32'hA0A0A0A0; #2;
        chk("t2_g1_addr", a_s_address, 32'h200);
        chk("t2_g1_sread", a_s_read, 1);
        chk("t2_g1_w1", a_m1_waitrequest, 0);
        chk("t2_g1_w0", a_m0_waitrequest, 1);
        chk("t2_a_rv0", a_m0_rdvalid, 1);
        chk("t2_a_rd0", a_m0_readdata, 32'hA0A0A0A0);
        chk("t2_b_rv0_early", b_m0_rdvalid, 0);
        nx(); m1_read = 0; s_readdata = 32'hB1B1B1B1; #2;
        chk("t2_a_rv1", a_m1_rdvalid, 1);
        chk("t2_a_rd1", a_m1_readdata, 32'hB1B1B1B1);
        chk("t2_a_rv0_end", a_m0_rdvalid, 0);
        chk("t5_b_rv0", b_m0_rdvalid, 1);
        chk("t5_b_rd0", b_m0_readdata, 32'hB1B1B1B1);
        chk("t5_b_rv1_early", b_m1_rdvalid, 0);
        nx(); s_readdata = 32'hC2C2C2C2; #2;
        chk("t5_b_rv1", b_m1_rdvalid, 1);
        chk("t5_b_rd1", b_m1_readdata, 32'hC2C2C2C2);
        chk("t5_b_rv0_end", b_m0_rdvalid, 0);
        chk("t2_a_rv1_end", a_m1_rdvalid, 0);

        // continuous contention: strict alternation, four accepts each
        rst_pulse();
        nx(); m0_write = 1; m0_address = 32'h300; m1_write = 1; m1_address = 32'h400; #2;
        chk("t3_idle", a_s_write, 0);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 8; i++) begin
            nx(); #2;
            chk($sformatf("t3_w0_%0d", i), a_m0_waitrequest, (i % 2) ? 1 : 0);
            chk($sformatf("t3_addr_%0d", i), a_s_address, (i % 2) ? 32'h400 : 32'h300);
            n0 += int'(a_s_write & ~a_m0_waitrequest);
            n1 += int'(a_s_write & ~a_m1_waitrequest);
        end
        chk("t3_n0", n0, 4);
        chk("t3_n1", n1, 4);
        nx(); m0_write = 0; m1_write = 0;

        // stalled M1 write blocks M0 until accepted
        nx(); m1_write = 1; m1_address = 32'h40; m1_writedata = 32'h1122; m1_byteenable = 4'b0011; s_waitrequest = 1; #2;
        chk("t4_idle", a_s_write, 0);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            nx();
            if (i == 0) begin m0_read = 1; m0_address = 32'h80; end
            s_waitrequest = (i == 3) ? 0 : 1;
            #2;
            chk($sformatf("t4_sw_%0d", i), a_s_write, 1);
            chk($sformatf("t4_w1_%0d", i), a_m1_waitrequest, (i == 3) ? 0 : 1);
            chk($sformatf("t4_w0_%0d", i), a_m0_waitrequest, 1);
            acc += int'(a_s_write & ~a_m1_waitrequest);
        end
        chk("t4_wdata", a_s_writedata, 32'h1122);
        chk("t4_be", a_s_byteenable, 4'b0011);
        chk("t4_acc", acc, 1);
        chk("t4_no_err", b_bus_error, 0);
        nx(); m1_write = 0; #2;
        chk("t4_m0_sread", a_s_read, 1);
        chk("t4_m0_addr", a_s_address, 32'h80);
        chk("t4_m0_w", a_m0_waitrequest, 0);
        chk("t4_m0_swrite", a_s_write, 0);
        nx(); m0_read = 0; #2;
        chk("t4_done", a_s_read, 0);
        nx();

        // permanent stall: timeout on 4th stalled cycle, sticky until reset
        nx(); m0_read = 1; m0_address = 32'h500; s_waitrequest = 1;
        for (int i = 1; i <= 6; i++) begin
            nx(); #2;
            chk($sformatf("t6_err_%0d", i), b_bus_error, (i >= 5) ? 1 : 0);
        end
        chk("t6_a_noerr", a_bus_error, 0);
        chk("t6_still_wait", b_m0_waitrequest, 1);
        nx(); reset = 1; #2;
        chk("t6_rst_a_sread", a_s_read, 0);
        chk("t6_rst_b_sread", b_s_read, 0);
        chk("t6_rst_wait", a_m0_waitrequest, 1);
        chk("t6_err_held", b_bus_error, 1);
        nx(); reset = 0; m0_read = 0; s_waitrequest = 0; #2;
        chk("t6_err_clr", b_bus_error, 0);
        chk("t6_b_sread", b_s_read, 0);
        chk("t6_b_saddr", b_s_address, 0);
        chk("t6_b_wait", b_m0_waitrequest, 1);
        chk("t6_b_rdvalid", b_m0_rdvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
